// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
// No logic; imported by the unit and its bench.
// Carries no flow control of its own.
package mult_div_unit_pkg;

    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_MULTU = 2'b01;
    localparam logic [1:0] MDU_OP_DIV   = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-facing bundle of the multiply/divide unit (controls in, HI/LO and status out).
// Pure wiring, zero latency; stall is the only backpressure and is driven by the unit.
// MDU_DIVZERO_EN adds the div_zero status bit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             read_hi;
    logic             read_lo;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;
`ifdef MDU_DIVZERO_EN
    logic             div_zero;
`endif

    modport master (
`ifdef MDU_DIVZERO_EN
        input  div_zero,
`endif
        output start, op, operand_a, operand_b,
        output read_hi, read_lo, write_hi, write_lo, wr_data,
        input  hi, lo, busy, done, stall
    );

    modport slave (
`ifdef MDU_DIVZERO_EN
        output div_zero,
`endif
        input  start, op, operand_a, operand_b,
        input  read_hi, read_lo, write_hi, write_lo, wr_data,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/mult_div_unit_iterate.sv
// One iteration of the unsigned shift-add multiply / restoring shift-subtract divide on {acc, opr}.
// Purely combinational, zero latency; no flow control.
// Multiply shifts right (product ends in {acc, opr}); divide shifts left (quotient in opr, remainder in acc).
module mdu_iterate #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opr_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opr_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, mcand_i};
        rem   = {acc_i, opr_i[WIDTH-1]};
        diff  = rem - {1'b0, mcand_i};
        acc_o = acc_i;
        opr_o = opr_i;
        if (is_div_i) begin
            // acc stays below the divisor, so diff[WIDTH] is a clean borrow flag
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                opr_o = {opr_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem[WIDTH-1:0];
                opr_o = {opr_i[WIDTH-2:0], 1'b0};
            end
        end else if (opr_i[0]) begin
            acc_o = sum[WIDTH:1];
            opr_o = {sum[0], opr_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[WIDTH-1:1]};
            opr_o = {acc_i[0], opr_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO (optional MDU_DIVZERO_EN).
// Latency WIDTH+2 cycles from start to done; divide-by-zero short-cuts to 2 cycles when enabled.
// Stalls the pipeline whenever HI/LO or a new start is touched while an operation is in flight.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mult_div_unit_if.slave mdu
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, opr_q, opr_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d, done_q, done_d;

    logic [WIDTH-1:0]   acc_nxt, opr_nxt, mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_neg;
    logic               signed_op, a_neg, b_neg, dz_start, busy;

    mdu_iterate #(.WIDTH(WIDTH)) u_iter (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opr_i    (opr_q),
        .mcand_i  (mcand_q),
        .acc_o    (acc_nxt),
        .opr_o    (opr_nxt)
    );

    assign signed_op = (mdu.op == MDU_OP_MULT) || (mdu.op == MDU_OP_DIV);
    assign a_neg     = signed_op & mdu.operand_a[WIDTH-1];
    assign b_neg     = signed_op & mdu.operand_b[WIDTH-1];
    assign mag_a     = a_neg ? -mdu.operand_a : mdu.operand_a;
    assign mag_b     = b_neg ? -mdu.operand_b : mdu.operand_b;
    assign prod_neg  = -{acc_q, opr_q};

`ifdef MDU_DIVZERO_EN
    assign dz_start = mdu.op[1] & (mdu.operand_b == '0);
`else
    assign dz_start = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mdu.start) begin
                    is_div_d = mdu.op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    dz_d     = dz_start;
                    acc_d    = '0;
                    opr_d    = mdu.op[1] ? mag_a : mag_b;
                    mcand_d  = mdu.op[1] ? mag_b : mag_a;
                    cnt_d    = CW'(WIDTH - 1);
                    // a zero divisor borrows FIXUP as its single busy cycle, with the write masked
                    state_d  = dz_start ? ST_FIXUP : ST_RUN;
                end else begin
                    if (mdu.write_hi) hi_d = mdu.wr_data;
                    if (mdu.write_lo) lo_d = mdu.wr_data;
                end
            end
            ST_RUN: begin
                acc_d = acc_nxt;
                opr_d = opr_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                if (!dz_q) begin
                    if (is_div_q) begin
                        lo_d = neg_lo_q ? -opr_q : opr_q;
                        hi_d = neg_hi_q ? -acc_q : acc_q;
                    end else begin
                        {hi_d, lo_d} = neg_lo_q ? prod_neg : {acc_q, opr_q};
                    end
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opr_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

`ifdef MDU_DIVZERO_EN
    logic div_zero_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) div_zero_q <= 1'b0;
        else       div_zero_q <= (state_q == ST_FIXUP) & dz_q;
    end

    assign mdu.div_zero = div_zero_q;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign mdu.busy  = busy;
    assign mdu.done  = done_q;
    assign mdu.hi    = hi_q;
    assign mdu.lo    = lo_q;
    assign mdu.stall = busy & (mdu.start | mdu.read_hi | mdu.read_lo | mdu.write_hi | mdu.write_lo);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: arithmetic results, latency, stall and reset behaviour.
// Follows the MDU_DIVZERO_EN build setting for the divide-by-zero case.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) mif ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mdu   (mif)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns in the done cycle (or after the bound expires).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int dcyc, output int busy_err);
        mif.start = 1'b1;
        mif.op = op;
        mif.operand_a = a;
        mif.operand_b = b;
        dcyc = -1;
        busy_err = 0;
        @(posedge clk); #1;
        mif.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (mif.done) begin
                dcyc = c;
                if (mif.busy) busy_err++;
                break;
            end
            if (!mif.busy) busy_err++;
            @(posedge clk); #1;
        end
    endtask

    int dcyc, berr, stall_err, extra_done, stall_at_start;

    initial begin
        mif.start = 0; mif.op = 0; mif.operand_a = 0; mif.operand_b = 0;
        mif.read_hi = 0; mif.read_lo = 0; mif.write_hi = 0; mif.write_lo = 0; mif.wr_data = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", mif.hi, 0);
        chk("rst_lo", mif.lo, 0);
        chk("rst_busy", mif.busy, 0);
        chk("rst_done", mif.done, 0);
        chk("rst_stall", mif.stall, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7, dcyc, berr);
        chk("mult_done_cyc", dcyc, 34);
        chk("mult_busy", berr, 0);
        chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
        chk("mult_lo", mif.lo, 32'hFFFF_FFEB);

        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, berr);
        chk("multu_done_cyc", dcyc, 34);
        chk("multu_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(MDU_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, berr);
        chk("mult_m1_hilo", {mif.hi, mif.lo}, 64'h0000_0000_0000_0001);

        run_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, dcyc, berr);
        chk("div_done_cyc", dcyc, 34);
        chk("div_busy", berr, 0);
        chk("div_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(MDU_OP_DIVU, 32'd100, 32'd7, dcyc, berr);
        chk("divu_hilo", {mif.hi, mif.lo}, {32'd2, 32'd14});

        run_op(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dcyc, berr);
        chk("div_minint_hilo", {mif.hi, mif.lo}, 64'h0000_0000_8000_0000);

        // DIVU 1000/3 with read_hi from cycle 5, a stray start at 10 and an mtlo at 12
        mif.start = 1'b1; mif.op = MDU_OP_DIVU; mif.operand_a = 32'd1000; mif.operand_b = 32'd3;
        @(posedge clk); #1;
        mif.start = 1'b0;
        dcyc = -1; stall_err = 0; stall_at_start = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) mif.read_hi = 1'b1;
            mif.start = (c == 10);
            mif.op = MDU_OP_MULT; mif.operand_a = 32'd7; mif.operand_b = 32'd7;
            mif.write_lo = (c == 12);
            mif.wr_data = 32'hDEAD_BEEF;
            #1;
            if (c == 10) stall_at_start = mif.stall;
            if (mif.done) begin
                dcyc = c;
                break;
            end
            if (c >= 5 && mif.stall !== 1'b1) stall_err++;
            @(posedge clk); #1;
        end
        chk("stall_done_cyc", dcyc, 34);
        chk("stall_held", stall_err, 0);
        chk("stall_on_busy_start", stall_at_start, 1);
        chk("stall_released", mif.stall, 0);
        chk("stall_hi", mif.hi, 32'd1);
        chk("stall_lo_no_write", mif.lo, 32'd333);
        mif.read_hi = 1'b0;
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mif.done) extra_done++;
        end
        chk("no_second_done", extra_done, 0);

        mif.write_hi = 1'b1; mif.read_hi = 1'b1; mif.wr_data = 32'h1234;
        #1;
        chk("mthi_same_cycle_old", mif.hi, 32'd1);
        chk("mthi_idle_stall", mif.stall, 0);
        @(posedge clk); #1;
        mif.write_hi = 1'b0; mif.read_hi = 1'b0;
        chk("mthi_hi", mif.hi, 32'h1234);
        mif.write_lo = 1'b1; mif.wr_data = 32'h5678;
        @(posedge clk); #1;
        mif.write_lo = 1'b0;
        chk("mtlo_lo", mif.lo, 32'h5678);

        run_op(MDU_OP_DIVU, 32'd5, 32'd0, dcyc, berr);
`ifdef MDU_DIVZERO_EN
        chk("dz_done_cyc", dcyc, 2);
        chk("dz_busy", berr, 0);
        chk("dz_flag", mif.div_zero, 1);
        chk("dz_hilo_kept", {mif.hi, mif.lo}, {32'h1234, 32'h5678});
`else
        chk("dz_done_cyc", dcyc, 34);
        chk("dz_busy", berr, 0);
        chk("dz_hilo", {mif.hi, mif.lo}, {32'd5, 32'hFFFF_FFFF});
`endif

        mif.start = 1'b1; mif.op = MDU_OP_DIV; mif.operand_a = 32'hFFFF_FF9C; mif.operand_b = 32'd7;
        @(posedge clk); #1;
        mif.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", mif.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", mif.busy, 0);
        chk("abort_done", mif.done, 0);
        chk("abort_hilo", {mif.hi, mif.lo}, 64'h0);
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mif.done) extra_done++;
        end
        chk("abort_no_done", extra_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
